// File: rtl/sort_arb_pkg.sv
// Shared types for the sort_arbiter slice: element/vector typedefs, the result
// FIFO entry and the requester-id width helper.
package sort_arb_pkg;

  localparam int SA_WIDTH   = 32;
  localparam int SA_DEPTH   = 8;
  localparam int SA_NUM_REQ = 4;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int SA_ID_W = id_width(SA_NUM_REQ);

  typedef logic [SA_WIDTH-1:0] elem_t;
  typedef elem_t [SA_DEPTH-1:0] vec_t;

  typedef struct packed {
    logic [SA_ID_W-1:0] id;
    vec_t               vec;
  } res_entry_t;

endpackage

// File: rtl/sort_arb_fifo.sv
// Synchronous show-ahead FIFO (D a power of 2). The head word is visible
// combinationally and reads as zero while the FIFO is empty.
module sort_arb_fifo #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [W-1:0]     wr_data,
  input  logic             rd_en,
  output logic [W-1:0]     rd_data,
  output logic             empty,
  output logic [$clog2(D):0] count
);

  localparam int AW = $clog2(D);

  logic [W-1:0]  mem [D];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_wr;
  logic          do_rd;

  // A write into a full FIFO is accepted only when a read frees a slot in the same cycle.
  assign do_rd = rd_en && (count_reg != '0);
  assign do_wr = wr_en && ((count_reg != (AW+1)'(D)) || do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign rd_data = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/sort_arbiter.sv
// Round-robin, credit-limited sharing of one in-order sorter among NUM_REQ requesters.
// Optional watchdog enabled by defining SORT_ARB_WDOG_EN.
module sort_arbiter
  import sort_arb_pkg::*;
#(
  parameter int WIDTH        = SA_WIDTH,
  parameter int DEPTH        = SA_DEPTH,
  parameter int NUM_REQ      = SA_NUM_REQ,
  parameter int MAX_INFLIGHT = 4,
  parameter int WDOG_CYCLES  = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*DEPTH*WIDTH-1:0]   req_data,
  output logic                             s_valid_in,
  output logic [DEPTH*WIDTH-1:0]           s_unsorted,
  input  logic                             s_valid_out,
  input  logic [DEPTH*WIDTH-1:0]           s_sorted,
  output logic                             resp_valid,
  input  logic                             resp_ready,
  output logic [$clog2(NUM_REQ)-1:0]       resp_id,
  output logic [DEPTH*WIDTH-1:0]           resp_data,
  output logic                             proto_err,
  output logic                             wdog_err
);

  localparam int ID_W  = id_width(NUM_REQ);
  localparam int VW    = DEPTH * WIDTH;
  localparam int CNT_W = $clog2(MAX_INFLIGHT) + 1;
  localparam int ENT_W = $bits(res_entry_t);

  logic [VW-1:0]    req_vec [NUM_REQ];
  logic [ID_W-1:0]  rr_ptr_reg;
  logic [ID_W-1:0]  rr_ptr_next;
  logic [ID_W-1:0]  winner;
  logic [ID_W:0]    cand;
  logic             found;
  logic             can_issue;
  logic             grant;
  logic             s_valid_in_reg;
  logic [VW-1:0]    s_unsorted_reg;
  logic             proto_err_reg;
  logic             tag_empty;
  logic             tag_pop;
  logic [ID_W-1:0]  tag_head;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] res_count;
  logic [CNT_W:0]   occupancy;
  logic             res_empty;
  res_entry_t       res_in;
  res_entry_t       res_out;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req_vec
      assign req_vec[gi] = req_data[gi*VW +: VW];
    end
  endgenerate

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_reg} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      if (!found && req_valid[cand[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[ID_W-1:0];
      end
    end
  end

  // Jobs in the sorter plus buffered results must never exceed the result FIFO depth.
  assign occupancy = {1'b0, inflight} + {1'b0, res_count};
  assign can_issue = occupancy < (CNT_W+1)'(MAX_INFLIGHT);

  always_comb begin
    req_ready = '0;
    if (rst && found && can_issue) req_ready[winner] = 1'b1;
  end

  assign grant       = |req_ready;
  assign rr_ptr_next = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_reg     <= '0;
      s_valid_in_reg <= 1'b0;
      s_unsorted_reg <= '0;
      proto_err_reg  <= 1'b0;
    end else begin
      s_valid_in_reg <= grant;
      if (grant) begin
        rr_ptr_reg     <= rr_ptr_next;
        s_unsorted_reg <= req_vec[winner];
      end
      if (s_valid_out && tag_empty) proto_err_reg <= 1'b1;
    end
  end

  // The tag FIFO occupancy is exactly the number of jobs inside the sorter.
  assign tag_pop = s_valid_out && !tag_empty;

  sort_arb_fifo #(.W(ID_W), .D(MAX_INFLIGHT)) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (grant),
    .wr_data (winner),
    .rd_en   (tag_pop),
    .rd_data (tag_head),
    .empty   (tag_empty),
    .count   (inflight)
  );

  always_comb begin
    res_in     = '0;
    res_in.id  = tag_head;
    res_in.vec = s_sorted;
  end

  sort_arb_fifo #(.W(ENT_W), .D(MAX_INFLIGHT)) u_res_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (tag_pop),
    .wr_data (res_in),
    .rd_en   (resp_valid && resp_ready),
    .rd_data (res_out),
    .empty   (res_empty),
    .count   (res_count)
  );

  assign resp_valid = !res_empty;
  assign resp_id    = res_out.id;
  assign resp_data  = res_out.vec;
  assign s_valid_in = s_valid_in_reg;
  assign s_unsorted = s_unsorted_reg;
  assign proto_err  = proto_err_reg;

`ifdef SORT_ARB_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);

  logic [WD_W-1:0] wdog_cnt_reg;
  logic            wdog_err_reg;

  // Flag raised on the same edge the count reaches WDOG_CYCLES.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_cnt_reg <= '0;
      wdog_err_reg <= 1'b0;
    end else if (s_valid_out) begin
      wdog_cnt_reg <= '0;
    end else if (inflight != '0 && wdog_cnt_reg != WD_W'(WDOG_CYCLES)) begin
      wdog_cnt_reg <= wdog_cnt_reg + 1'b1;
      if (wdog_cnt_reg == WD_W'(WDOG_CYCLES - 1)) wdog_err_reg <= 1'b1;
    end
  end

  assign wdog_err = wdog_err_reg;
`else
  assign wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_sort_arbiter.sv
// Directed bench for sort_arbiter: a one-cycle sorter stub returns results and a
// scoreboard queue checks every response id and vector.
module tb_sort_arbiter;
  import sort_arb_pkg::*;

  localparam int W  = 32;
  localparam int D  = 8;
  localparam int N  = 4;
  localparam int VW = W * D;
`ifdef SORT_ARB_WDOG_EN
  localparam bit WDOG_EXP = 1'b1;
`else
  localparam bit WDOG_EXP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*VW-1:0] req_data = '0;
  logic            s_valid_in;
  logic [VW-1:0]   s_unsorted;
  logic            s_valid_out;
  logic [VW-1:0]   s_sorted;
  logic            resp_valid;
  logic            resp_ready = 1'b0;
  logic [1:0]      resp_id;
  logic [VW-1:0]   resp_data;
  logic            proto_err;
  logic            wdog_err;

  int errors = 0;
  int checks = 0;
  int unsorted_base [D] = '{10, 3, 25, 7, 1, 18, 2, 5};
  int sorted_base   [D] = '{1, 2, 3, 5, 7, 10, 18, 25};

  typedef struct {
    int            id;
    logic [VW-1:0] v;
  } exp_t;
  exp_t sb [$];
  exp_t mon_e;

  logic          model_v     = 1'b0;
  logic [VW-1:0] model_d     = '0;
  logic          force_vo    = 1'b0;
  logic          sorter_hold = 1'b0;

  sort_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_data    (req_data),
    .s_valid_in  (s_valid_in),
    .s_unsorted  (s_unsorted),
    .s_valid_out (s_valid_out),
    .s_sorted    (s_sorted),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_data   (resp_data),
    .proto_err   (proto_err),
    .wdog_err    (wdog_err)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] sort8(input logic [VW-1:0] v);
    logic [W-1:0]  e [D];
    logic [W-1:0]  t;
    logic [VW-1:0] r;
    for (int k = 0; k < D; k++) e[k] = v[k*W +: W];
    for (int a = 0; a < D - 1; a++)
      for (int b = 0; b < D - 1 - a; b++)
        if (e[b] > e[b+1]) begin
          t = e[b]; e[b] = e[b+1]; e[b+1] = t;
        end
    r = '0;
    for (int k = 0; k < D; k++) r[k*W +: W] = e[k];
    return r;
  endfunction

  function automatic logic [VW-1:0] unsorted_vec(input int id);
    logic [VW-1:0] r = '0;
    for (int k = 0; k < D; k++) r[k*W +: W] = W'(unsorted_base[k] + id);
    return r;
  endfunction

  function automatic logic [VW-1:0] sorted_vec(input int id);
    logic [VW-1:0] r = '0;
    for (int k = 0; k < D; k++) r[k*W +: W] = W'(sorted_base[k] + id);
    return r;
  endfunction

  // Sorter stub: one cycle of latency, drops jobs while sorter_hold is set.
  always @(posedge clk) begin
    model_v <= s_valid_in && !sorter_hold;
    model_d <= sort8(s_unsorted);
  end
  assign s_valid_out = model_v | force_vo;
  assign s_sorted    = model_d;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: push on grant, pop and compare on response handshake.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++)
        if (req_ready[i]) begin
          mon_e.id = i;
          mon_e.v  = sorted_vec(i);
          sb.push_back(mon_e);
        end
      if (resp_valid && resp_ready) begin
        chk("sb_pending", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          chk("resp_id", resp_id, mon_e.id);
          chk("resp_data", resp_data, mon_e.v);
          $display("resp id=%0d data=%0h", resp_id, resp_data);
        end
      end
    end
  end

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (|req_ready) ok = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic drain(input string tag);
    int c = 0;
    while ((sb.size() != 0 || resp_valid) && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    chk(tag, sb.size(), 0);
  endtask

  initial begin
    bit ok;
    int grants;

    for (int i = 0; i < N; i++) req_data[i*VW +: VW] = unsorted_vec(i);

    // Reset state
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_s_valid_in", s_valid_in, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_wdog_err", wdog_err, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // All requesters valid: grants rotate 0,1,2,3,0,...
    resp_ready = 1'b1;
    req_valid  = 4'hF;
    for (int n = 0; n < 8; n++) begin
      wait_grant(ok);
      chk("t1_grant_seen", ok, 1);
      chk("t1_grant_order", req_ready, 1 << (n % 4));
      $display("grant n=%0d req_ready=%b", n, req_ready);
      @(posedge clk); #1;
    end
    req_valid = '0;
    drain("t1_drain");

    // Credit limit: 4 grants with resp_ready low, then one grant per pop
    resp_ready = 1'b0;
    req_valid  = 4'b0010;
    grants = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (|req_ready) grants++;
      @(posedge clk); #1;
    end
    chk("t2_grants_blocked", grants, 4);
    @(negedge clk);
    chk("t2_ready_low", req_ready, 0);
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    grants = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (|req_ready) grants++;
      @(posedge clk); #1;
    end
    chk("t2_grant_per_pop", grants, 1);
    @(negedge clk);
    chk("t2_ready_low_again", req_ready, 0);
    @(posedge clk); #1;
    resp_ready = 1'b1;
    req_valid  = '0;
    drain("t2_drain");

    // Requesters 0 and 2 with rr_ptr=1: grant 2 then 0
    req_valid = 4'b0001;
    wait_grant(ok);
    chk("t3_setup_grant", req_ready, 4'b0001);
    @(posedge clk); #1;
    req_valid = 4'b0101;
    @(negedge clk);
    chk("t3_first_grant", req_ready, 4'b0100);
    @(posedge clk); #1;
    chk("t3_s_valid_in", s_valid_in, 1);
    chk("t3_s_unsorted", s_unsorted, unsorted_vec(2));
    @(negedge clk);
    chk("t3_second_grant", req_ready, 4'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    drain("t3_drain");

    // Sorter result with no job issued
    force_vo = 1'b1;
    @(posedge clk); #1;
    force_vo = 1'b0;
    @(negedge clk);
    chk("t4_proto_err", proto_err, 1);
    chk("t4_resp_valid", resp_valid, 0);
    @(negedge clk);
    chk("t4_resp_valid_later", resp_valid, 0);

    // Reset pulse clears the sticky flag
    @(posedge clk); #1;
    rst = 1'b0;
    #1 chk("t5_proto_cleared", proto_err, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Three jobs that never return, then an asynchronous reset mid-flight
    sorter_hold = 1'b1;
    resp_ready  = 1'b0;
    req_valid   = 4'hF;
    for (int g = 0; g < 3; g++) begin
      wait_grant(ok);
      chk("t5_grant_seen", ok, 1);
      @(posedge clk); #1;
    end
    req_valid = '0;
    repeat (70) @(posedge clk);
    #1 req_valid = 4'hF;
    @(negedge clk);
    chk("t5_wdog_err", wdog_err, WDOG_EXP);
    chk("t5_no_resp", resp_valid, 0);
    chk("t5_credit_left", req_ready != 0, 1);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("t5_rst_req_ready", req_ready, 0);
    chk("t5_rst_s_valid_in", s_valid_in, 0);
    chk("t5_rst_s_unsorted", s_unsorted, 0);
    chk("t5_rst_resp_valid", resp_valid, 0);
    chk("t5_rst_resp_id", resp_id, 0);
    chk("t5_rst_resp_data", resp_data, 0);
    chk("t5_rst_wdog_err", wdog_err, 0);
    sb.delete();
    @(negedge clk);
    chk("t5_rst_hold_ready", req_ready, 0);
    @(posedge clk); #1;
    rst       = 1'b1;
    req_valid = '0;
    chk("t5_post_rst_proto", proto_err, 0);
    force_vo = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    force_vo = 1'b0;
    @(negedge clk);
    chk("t5_late_proto_err", proto_err, 1);
    chk("t5_late_resp_valid", resp_valid, 0);
    chk("t5_late_resp_data", resp_data, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sort_arbiter.md
# sort_arbiter

Shares one bitonic sorter core (WIDTH=32, DEPTH=8, fixed-latency, in-order, no backpressure) between NUM_REQ requesters. Round-robin arbitration selects one vector per cycle, drives the sorter's valid_in/unsorted port, and tracks requester IDs in an in-order tag FIFO. Sorted results are buffered in a result FIFO and returned on a single ready/valid response port tagged with the originating requester ID. Issue is credit-limited so that no sorter output can ever be dropped.

## Interface
- WIDTH, 32, element width in bits
- DEPTH, 8, elements per vector (power of 2)
- NUM_REQ, 4, number of requesters (≥2)
- MAX_INFLIGHT, 4, result-buffer depth = max jobs in sorter plus buffered (power of 2)
- WDOG_CYCLES, 64, watchdog limit (used only with the watchdog macro)
---
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester job valid
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
- req_data  in  NUM_REQ×DEPTH×WIDTH  vectors; requester i element k at [(i*DEPTH+k)*WIDTH +: WIDTH]
- s_valid_in  out  1  sorter input valid, registered
- s_unsorted  out  DEPTH×WIDTH  sorter input vector, registered
- s_valid_out  in  1  sorter result valid
- s_sorted  in  DEPTH×WIDTH  sorter result vector
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_id  out  $clog2(NUM_REQ)  originating requester
- resp_data  out  DEPTH×WIDTH  sorted vector
- proto_err  out  1  sticky: s_valid_out arrived with empty tag FIFO
- wdog_err  out  1  sticky watchdog flag

## Operation
- credits = MAX_INFLIGHT − (inflight + result-FIFO count). Issue allowed only when credits > 0.
- Arbitration: round-robin pointer rr_ptr. The winner is the first i with req_valid[i], searching from rr_ptr upward with wrap. When issue is allowed, req_ready[winner]=1 and all other req_ready bits are 0. req_ready is combinational from req_valid, rr_ptr and credits.
- On grant of requester g:
  - rr_ptr ← (g+1) mod NUM_REQ.
  - Push g into the tag FIFO.
  - inflight++.
  - Register s_valid_in=1 and s_unsorted=req_data[g] for exactly one cycle.
- With no grant, s_valid_in=0 and s_unsorted holds its last value.
- On s_valid_out:
  - Pop the tag FIFO.
  - inflight−−.
  - Push {tag, s_sorted} into the result FIFO.
- Simultaneous grant and s_valid_out: both updates apply and inflight is unchanged.
- resp_valid = result FIFO not empty. resp_id and resp_data show the FIFO head. A pop occurs on resp_valid&&resp_ready.
  - Simultaneous push and pop on a full FIFO is legal.
  - The credit rule makes push-when-full impossible.
- s_valid_out with an empty tag FIFO:
  - Set proto_err.
  - Push nothing.
  - Do not decrement inflight (saturates at 0).
- Reset (async, mid-operation) does all of the following:
  - Clears both FIFOs, inflight, rr_ptr=0 and both error flags.
  - Discards in-flight jobs.
  - Forces all outputs to 0.

## Timing
- Grant in cycle N → s_valid_in high in cycle N+1.
- Result reaches resp_valid one cycle after s_valid_out (FIFO registered write, show-ahead read).
- Back-to-back grants are allowed every cycle while credits remain.
- Credits freed by a resp pop in cycle N are usable for a grant in cycle N+1.
- Full throughput of one job per cycle requires MAX_INFLIGHT ≥ sorter latency + 2.

## Configuration
- SORT_ARB_WDOG_EN defined:
  - A counter runs while inflight>0 and resets on every s_valid_out.
  - When the counter reaches WDOG_CYCLES, wdog_err is set (sticky until reset).
- SORT_ARB_WDOG_EN undefined: no counter; wdog_err tied 0.

## Structure
- Package sort_arb_pkg holds:
  - element/vector typedefs (elem_t, vec_t),
  - the result entry struct {id, vec},
  - the id width function.
- One sub-module: sort_arb_fifo (parameterised sync FIFO, show-ahead). It is instantiated twice: tag FIFO (id width) and result FIFO (entry width).

## Test plan
- All 4 requesters valid continuously, resp_ready=1, vectors {10,3,25,7,1,18,2,5}+i → grants in order 0,1,2,3,0…; each resp_data = {1,2,3,5,7,10,18,25}+i with matching resp_id.
- resp_ready=0, MAX_INFLIGHT=4, requester 1 valid → exactly 4 grants, then req_ready stays 0. Raise resp_ready → one new grant per popped result.
- Requesters 0 and 2 only, rr_ptr=1 → first grant is 2, then 0.
- Force s_valid_out with no issue → proto_err=1, resp_valid stays 0.
- Assert rst low mid-flight with 3 jobs in flight → all outputs 0 immediately. After release, late s_valid_out pulses set proto_err and produce no response.
- With SORT_ARB_WDOG_EN and a stubbed sorter that never returns, WDOG_CYCLES=64 → wdog_err rises 64 cycles after the first issue. Without the macro, wdog_err stays 0.
